// File: rtl/adder_pkg.sv
// adder_pkg: shared width default and flag bundle for the registered adder
package adder_pkg;
  localparam int DEFAULT_WIDTH = 32;
  typedef struct packed {
    logic carry;
    logic ovf;
  } add_flags_t;
endpackage

// File: rtl/registered_adder_if.sv
// registered_adder_if: operand/result bus between a producer and the registered adder
interface registered_adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             IN_VALID;
  logic [WIDTH-1:0] DATA_IN_1;
  logic [WIDTH-1:0] DATA_IN_2;
  logic [WIDTH-1:0] DATA_OUT;
  logic             CARRY_OUT;
  logic             OVERFLOW;
  logic             ZERO;
  logic             OUT_VALID;
  modport master (
    output IN_VALID, DATA_IN_1, DATA_IN_2,
    input  DATA_OUT, CARRY_OUT, OVERFLOW, ZERO, OUT_VALID
  );
  modport slave (
    input  IN_VALID, DATA_IN_1, DATA_IN_2,
    output DATA_OUT, CARRY_OUT, OVERFLOW, ZERO, OUT_VALID
  );
endinterface

// File: rtl/adder_core.sv
// adder_core: combinational WIDTH-bit add with unsigned carry and signed overflow
module adder_core
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output add_flags_t       flags_o
);
  logic [WIDTH:0] full;
  always_comb begin
    full          = {1'b0, a_i} + {1'b0, b_i};
    sum_o         = full[WIDTH-1:0];
    flags_o.carry = full[WIDTH];
    flags_o.ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (full[WIDTH-1] != a_i[WIDTH-1]);
  end
endmodule

// File: rtl/registered_adder.sv
// registered_adder: adder_core with valid-gated result registers and a zero decode
module registered_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               CLK,
  input  logic               RST_N,
  registered_adder_if.slave  bus
);
  logic [WIDTH-1:0] sum, data_q, data_d;
  add_flags_t       flags, flags_q, flags_d;
  logic             valid_q, valid_d;
  adder_core #(.WIDTH(WIDTH)) u_core (
    .a_i    (bus.DATA_IN_1),
    .b_i    (bus.DATA_IN_2),
    .sum_o  (sum),
    .flags_o(flags)
  );
  always_comb begin
    data_d  = bus.IN_VALID ? sum : data_q;
    flags_d = bus.IN_VALID ? flags : flags_q;
    valid_d = bus.IN_VALID;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_q  <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
    end
  end
  // ZERO decodes the register, so it can never disagree with DATA_OUT
  assign bus.DATA_OUT  = data_q;
  assign bus.CARRY_OUT = flags_q.carry;
  assign bus.OVERFLOW  = flags_q.ovf;
  assign bus.ZERO      = (data_q == '0);
  assign bus.OUT_VALID = valid_q;
endmodule

// File: tb/tb_registered_adder.sv
// tb_registered_adder: table vectors, random traffic and reset corners against a queue scoreboard
module tb_registered_adder;
  typedef struct {
    logic [31:0] data;
    logic        carry;
    logic        ovf;
    logic        zero;
  } res_t;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    res_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  res_t sb[$];
  res_t last;
  vec_t tbl[6];

  registered_adder_if #(.WIDTH(32)) bus ();
  registered_adder #(.WIDTH(32)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint us, ss;
    us = longint'(a) + longint'(b);
    ss = longint'($signed(a)) + longint'($signed(b));
    r.data  = us[31:0];
    r.carry = us >= 64'sh1_0000_0000;
    r.ovf   = (ss > 64'sh7FFF_FFFF) || (ss < -64'sh8000_0000);
    r.zero  = (r.data == 32'd0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_res(input string tag, input res_t e);
    chk({tag, ".data"}, bus.DATA_OUT, e.data);
    chk({tag, ".carry"}, bus.CARRY_OUT, e.carry);
    chk({tag, ".ovf"}, bus.OVERFLOW, e.ovf);
    chk({tag, ".zero"}, bus.ZERO, e.zero);
  endtask

  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b, input res_t e);
    res_t got;
    bus.IN_VALID  = v;
    bus.DATA_IN_1 = a;
    bus.DATA_IN_2 = b;
    if (v) sb.push_back(e);
    @(posedge clk);
    #1;
    chk("out_valid", bus.OUT_VALID, v);
    if (v) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        got = sb.pop_front();
        chk_res("result", got);
        last = got;
      end
    end else chk_res("hold", last);
  endtask

  task automatic chk_reset(input string tag);
    res_t z;
    z = '{data: 32'd0, carry: 1'b0, ovf: 1'b0, zero: 1'b1};
    chk({tag, ".out_valid"}, bus.OUT_VALID, 0);
    chk_res(tag, z);
    last = z;
    sb.delete();
  endtask

  initial begin
    res_t dc;
    dc = '{data: 32'd0, carry: 1'b0, ovf: 1'b0, zero: 1'b0};
    tbl[0] = '{32'd100, 32'd4, '{32'd104, 1'b0, 1'b0, 1'b0}};
    tbl[1] = '{32'd80, 32'd110, '{32'd190, 1'b0, 1'b0, 1'b0}};
    tbl[2] = '{32'hFFFF_FFFF, 32'd1, '{32'd0, 1'b1, 1'b0, 1'b1}};
    tbl[3] = '{32'h7FFF_FFFF, 32'd1, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
    tbl[4] = '{32'h8000_0000, 32'h8000_0000, '{32'd0, 1'b1, 1'b1, 1'b1}};
    tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0}};
    bus.IN_VALID  = 1'b0;
    bus.DATA_IN_1 = 32'd0;
    bus.DATA_IN_2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) step(1'b1, tbl[i].a, tbl[i].b, tbl[i].exp);
    step(1'b0, 32'h1234_5678, 32'h0BAD_F00D, dc);

    step(1'b1, 32'd100, 32'd4, model(32'd100, 32'd4));
    step(1'b1, 32'd80, 32'd110, model(32'd80, 32'd110));
    for (int i = 0; i < 3; i++) step(1'b0, $urandom, $urandom, dc);
    chk("hold_190", bus.DATA_OUT, 32'd190);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic v;
      a = $urandom;
      b = (i % 5 == 0) ? ~a + 32'd1 : $urandom;
      v = ($urandom_range(0, 3) != 0);
      step(v, a, b, model(a, b));
    end

    step(1'b1, 32'd5, 32'd6, model(32'd5, 32'd6));
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    rst_n = 1'b1;

    bus.IN_VALID  = 1'b1;
    bus.DATA_IN_1 = 32'h7FFF_FFFF;
    bus.DATA_IN_2 = 32'h7FFF_FFFF;
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("inflight_rst");
    rst_n = 1'b1;
    step(1'b0, 32'hDEAD_BEEF, 32'h1, dc);
    step(1'b1, 32'd7, 32'd9, model(32'd7, 32'd9));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
